// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (F stage) and
// a data requester (M stage). One transaction is outstanding at a time. Ties
// in IDLE go to the requester that was not served last. Fetches can be
// cancelled by a flush while in flight. A timeout counter completes a stuck
// transaction with an error pulse and a dummy response.
//
// Ports
//   clk, reset                  single clock, asynchronous active-high reset
//   IReqF, IAddrF, FlushF       fetch request / address / flush
//   DReqM, DWeM, DAddrM,
//   DWdataM, DBeM               data request / store / address / data / bytes
//   MemReq, MemWe, MemAddr,
//   MemWdata, MemBe             registered memory port command
//   MemAck, MemRdata            memory completion strobe and read data
//   InstrF, IValidF             registered fetch response (one-cycle valid)
//   DRdataM, DValidM            registered data response (one-cycle valid)
//   StallF, StallM              combinational pipeline freeze requests
//   BusErr                      one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  input  logic              FlushF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [31:0]       DWdataM,
  input  logic [3:0]        DBeM,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWdata,
  output logic [3:0]        MemBe,
  input  logic              MemAck,
  input  logic [31:0]       MemRdata,
  output logic [31:0]       InstrF,
  output logic              IValidF,
  output logic [31:0]       DRdataM,
  output logic              DValidM,
  output logic              StallF,
  output logic              StallM,
  output logic              BusErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  // Response returned for a timed-out fetch: RISC-V NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t           state;
  state_t           state_d;
  gnt_t             last_gnt;
  logic             cancel;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_cnt_inc;

  logic             i_ok;
  logic             busy;
  logic             ack_hit;
  logic             tmo_hit;
  logic             gnt_i;
  logic             gnt_d;

  // A flush in the same cycle blocks a new fetch grant.
  assign i_ok        = IReqF & ~FlushF;
  assign tmo_cnt_inc = tmo_cnt + TMO_W'(1);

  assign StallF = IReqF & ~IValidF;
  assign StallM = DReqM & ~DValidM;

  // Next-state and grant decode.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    busy    = (state == BUSY_I) || (state == BUSY_D);
    ack_hit = busy & MemAck;
    // The waited cycle that would carry the counter to all-ones is the
    // timeout; an ack in that same cycle takes priority.
    tmo_hit = busy & ~MemAck & (&tmo_cnt_inc);

    case (state)
      IDLE: begin
        if (DReqM && i_ok) begin
          if (last_gnt == GNT_FETCH) gnt_d = 1'b1;
          else                       gnt_i = 1'b1;
        end else if (DReqM) begin
          gnt_d = 1'b1;
        end else if (i_ok) begin
          gnt_i = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (ack_hit || tmo_hit) state_d = RESP;
      end
      RESP: begin
        // last_gnt already names the requester that just completed; only
        // the other one may be granted straight out of RESP.
        if (last_gnt == GNT_DATA && i_ok)       gnt_i = 1'b1;
        else if (last_gnt == GNT_FETCH && DReqM) gnt_d = 1'b1;
        else                                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (gnt_i) state_d = BUSY_I;
    if (gnt_d) state_d = BUSY_D;
  end

  // State, port command and response registers.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= GNT_FETCH;
      cancel   <= 1'b0;
      tmo_cnt  <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      MemBe    <= '0;
      InstrF   <= '0;
      IValidF  <= 1'b0;
      DRdataM  <= '0;
      DValidM  <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      state   <= state_d;
      IValidF <= 1'b0;
      DValidM <= 1'b0;
      BusErr  <= 1'b0;

      if (gnt_i || gnt_d) begin
        tmo_cnt <= '0;
        cancel  <= 1'b0;
        MemReq  <= 1'b1;
        if (gnt_d) begin
          MemWe    <= DWeM;
          MemAddr  <= DAddrM;
          MemWdata <= DWdataM;
          MemBe    <= DBeM;
        end else begin
          MemWe    <= 1'b0;
          MemAddr  <= IAddrF;
          MemWdata <= '0;
          MemBe    <= '0;
        end
      end else if (busy) begin
        if (ack_hit || tmo_hit) begin
          MemReq <= 1'b0;
          cancel <= 1'b0;
          BusErr <= tmo_hit;
          if (state == BUSY_I) begin
            last_gnt <= GNT_FETCH;
            // A cancelled fetch still completes on the port but is dropped.
            if (!(cancel || FlushF)) begin
              IValidF <= 1'b1;
              InstrF  <= ack_hit ? MemRdata : NOP_INSTR;
            end
          end else begin
            last_gnt <= GNT_DATA;
            DValidM  <= 1'b1;
            // Stores leave the previous read data in place.
            if (!MemWe) DRdataM <= ack_hit ? MemRdata : 32'h0;
          end
        end else begin
          tmo_cnt <= tmo_cnt_inc;
          if (state == BUSY_I && FlushF) cancel <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter: a table of per-cycle vectors with
// hand-computed expected outputs, followed by hand-written sequences for
// flush cancellation, timeouts and reset in mid-transaction.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReqF;
  logic [31:0] IAddrF;
  logic        FlushF;
  logic        DReqM;
  logic        DWeM;
  logic [31:0] DAddrM;
  logic [31:0] DWdataM;
  logic [3:0]  DBeM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic [31:0] InstrF;
  logic        IValidF;
  logic [31:0] DRdataM;
  logic        DValidM;
  logic        StallF;
  logic        StallM;
  logic        BusErr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .TMO_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .IReqF    (IReqF),
    .IAddrF   (IAddrF),
    .FlushF   (FlushF),
    .DReqM    (DReqM),
    .DWeM     (DWeM),
    .DAddrM   (DAddrM),
    .DWdataM  (DWdataM),
    .DBeM     (DBeM),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWdata (MemWdata),
    .MemBe    (MemBe),
    .MemAck   (MemAck),
    .MemRdata (MemRdata),
    .InstrF   (InstrF),
    .IValidF  (IValidF),
    .DRdataM  (DRdataM),
    .DValidM  (DValidM),
    .StallF   (StallF),
    .StallM   (StallM),
    .BusErr   (BusErr)
  );

  // Inputs applied for one cycle; stalls are checked before the edge,
  // everything else after it.
  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        flush;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        ack;
    logic [31:0] rdata;
    logic        sf;
    logic        sm;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        iv;
    logic [31:0] instr;
    logic        dv;
    logic [31:0] drd;
    logic        berr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    IReqF = 0; IAddrF = 0; FlushF = 0;
    DReqM = 0; DWeM = 0; DAddrM = 0; DWdataM = 0; DBeM = 0;
    MemAck = 0; MemRdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    IReqF = v.ireq; IAddrF = v.iaddr; FlushF = v.flush;
    DReqM = v.dreq; DWeM = v.dwe; DAddrM = v.daddr; DWdataM = v.dwdata; DBeM = v.dbe;
    MemAck = v.ack; MemRdata = v.rdata;
    #1;
    check($sformatf("v%0d StallF", idx), StallF, v.sf);
    check($sformatf("v%0d StallM", idx), StallM, v.sm);
    tick();
    check($sformatf("v%0d MemReq", idx),   MemReq,   v.mreq);
    check($sformatf("v%0d MemWe", idx),    MemWe,    v.mwe);
    check($sformatf("v%0d MemAddr", idx),  MemAddr,  v.maddr);
    check($sformatf("v%0d MemWdata", idx), MemWdata, v.mwdata);
    check($sformatf("v%0d MemBe", idx),    MemBe,    v.mbe);
    check($sformatf("v%0d IValidF", idx),  IValidF,  v.iv);
    check($sformatf("v%0d InstrF", idx),   InstrF,   v.instr);
    check($sformatf("v%0d DValidM", idx),  DValidM,  v.dv);
    check($sformatf("v%0d DRdataM", idx),  DRdataM,  v.drd);
    check($sformatf("v%0d BusErr", idx),   BusErr,   v.berr);
  endtask

  // Counts cycles with MemReq high after a grant, bounded so a stuck DUT
  // still reaches the summary.
  task automatic count_busy(output int n);
    n = 0;
    while (MemReq && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    // ireq iaddr flush dreq dwe daddr dwdata dbe ack rdata | sf sm mreq mwe maddr mwdata mbe iv instr dv drd berr
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0,0,0,0,0});
    // Simultaneous fetch and load after reset: data wins, fetch follows from RESP.
    vecs.push_back('{1,32'h200,0,1,0,32'h40,0,4'hF,0,0,                1,1,1,0,32'h40,0,4'hF,0,0,0,0,0});
    vecs.push_back('{1,32'h200,0,1,0,32'h40,0,4'hF,1,32'hCAFE0001,     1,1,0,0,32'h40,0,4'hF,0,0,1,32'hCAFE0001,0});
    vecs.push_back('{1,32'h200,0,1,0,32'h40,0,4'hF,0,0,                1,0,1,0,32'h200,0,0,0,0,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h200,0,0,0,0,0,0,1,32'h00A00113,             1,0,0,0,32'h200,0,0,1,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h200,0,0,0,0,0,0,0,0,                        0,0,0,0,32'h200,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,                              0,0,0,0,32'h200,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    // Fetch from 0x100, ack three cycles after MemReq rises.
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,0,0,                        1,0,1,0,32'h100,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,0,0,                        1,0,1,0,32'h100,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,0,0,                        1,0,1,0,32'h100,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,0,0,                        1,0,1,0,32'h100,0,0,0,32'h00A00113,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,1,32'h00500093,             1,0,0,0,32'h100,0,0,1,32'h00500093,0,32'hCAFE0001,0});
    vecs.push_back('{1,32'h100,0,0,0,0,0,0,0,0,                        0,0,0,0,32'h100,0,0,0,32'h00500093,0,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,                              0,0,0,0,32'h100,0,0,0,32'h00500093,0,32'hCAFE0001,0});
    // Store: read data must hold its previous value.
    vecs.push_back('{0,0,0,1,1,32'h2004,32'hDEADBEEF,4'h3,0,0,         0,1,1,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,0,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,1,1,32'h2004,32'hDEADBEEF,4'h3,1,32'h12345678, 0,1,0,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,1,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,1,1,32'h2004,32'hDEADBEEF,4'h3,0,0,         0,0,0,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,0,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,0,0,                              0,0,0,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,0,32'hCAFE0001,0});
    // Flush in IDLE blocks the fetch grant; a stray ack in IDLE is ignored.
    vecs.push_back('{1,32'h300,1,0,0,0,0,0,0,0,                        1,0,0,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,0,32'hCAFE0001,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,1,32'hFFFFFFFF,                   0,0,0,1,32'h2004,32'hDEADBEEF,4'h3,0,32'h00500093,0,32'hCAFE0001,0});

    // Reset state.
    idle_inputs();
    reset = 1'b1;
    #12;
    check("rst MemReq",  MemReq,  0);
    check("rst MemAddr", MemAddr, 0);
    check("rst InstrF",  InstrF,  0);
    check("rst DRdataM", DRdataM, 0);
    check("rst BusErr",  BusErr,  0);
    tick();
    reset = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Flush while fetch in flight: ack later is dropped, next fetch normal.
    idle_inputs();
    IReqF = 1; IAddrF = 32'h400;
    tick();
    check("fl grant MemReq", MemReq, 1);
    check("fl grant MemAddr", MemAddr, 32'h400);
    FlushF = 1; IAddrF = 32'h500;
    tick();
    check("fl latched MemAddr", MemAddr, 32'h400);
    FlushF = 0;
    tick();
    check("fl busy MemReq", MemReq, 1);
    MemAck = 1; MemRdata = 32'h11111111;
    tick();
    check("fl ack IValidF", IValidF, 0);
    check("fl ack InstrF", InstrF, 32'h00500093);
    check("fl ack MemReq", MemReq, 0);
    MemAck = 0; MemRdata = 0;
    tick();
    check("fl resp IValidF", IValidF, 0);
    check("fl resp MemReq", MemReq, 0);
    tick();
    check("fl regrant MemReq", MemReq, 1);
    check("fl regrant MemAddr", MemAddr, 32'h500);
    MemAck = 1; MemRdata = 32'h22222222;
    tick();
    check("fl next IValidF", IValidF, 1);
    check("fl next InstrF", InstrF, 32'h22222222);
    idle_inputs();
    tick();

    // Load timeout: 15 waited cycles, then BusErr and zero read data.
    DReqM = 1; DAddrM = 32'h80; DBeM = 4'hF;
    tick();
    count_busy(n);
    check("to load busy cycles", n, 15);
    check("to load BusErr", BusErr, 1);
    check("to load DValidM", DValidM, 1);
    check("to load DRdataM", DRdataM, 0);
    idle_inputs();
    tick();
    check("to load BusErr pulse", BusErr, 0);

    // Fetch timeout returns a NOP.
    IReqF = 1; IAddrF = 32'h600;
    tick();
    count_busy(n);
    check("to fetch busy cycles", n, 15);
    check("to fetch BusErr", BusErr, 1);
    check("to fetch IValidF", IValidF, 1);
    check("to fetch InstrF", InstrF, 32'h00000013);
    idle_inputs();
    tick();

    // Ack in the last possible cycle beats the timeout.
    DReqM = 1; DAddrM = 32'h90; DBeM = 4'hF;
    tick();
    repeat (14) tick();
    check("late ack MemReq", MemReq, 1);
    MemAck = 1; MemRdata = 32'h5A5A5A5A;
    tick();
    check("late ack BusErr", BusErr, 0);
    check("late ack DValidM", DValidM, 1);
    check("late ack DRdataM", DRdataM, 32'h5A5A5A5A);
    idle_inputs();
    tick();

    // Reset while BUSY_D: immediate drop, no response, later ack ignored.
    DReqM = 1; DAddrM = 32'hC0; DBeM = 4'hF;
    tick();
    check("rb busy MemReq", MemReq, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rb async MemReq", MemReq, 0);
    check("rb async DValidM", DValidM, 0);
    idle_inputs();
    tick();
    reset = 1'b0;
    MemAck = 1; MemRdata = 32'h77777777;
    tick();
    check("rb stray DValidM", DValidM, 0);
    check("rb stray DRdataM", DRdataM, 0);
    check("rb stray MemReq", MemReq, 0);

    // Tie after reset goes to data again.
    idle_inputs();
    IReqF = 1; IAddrF = 32'h700; DReqM = 1; DAddrM = 32'hD0; DBeM = 4'hF;
    tick();
    check("rb tie MemAddr", MemAddr, 32'hD0);
    MemAck = 1; MemRdata = 32'h33333333;
    tick();
    check("rb tie DValidM", DValidM, 1);
    MemAck = 0; DReqM = 0;
    tick();
    check("rb tie fetch MemAddr", MemAddr, 32'h700);
    MemAck = 1; MemRdata = 32'h44444444;
    tick();
    check("rb tie IValidF", IValidF, 1);
    check("rb tie InstrF", InstrF, 32'h44444444);
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
